config_loader: RTL and testbench
================================

// Module: config_loader
// PURPOSE
//  Bitstream loader directly upstream of a logic tile's configuration shift register chain.
//  Accepts configuration words over a valid/ready stream and serializes them onto the chain.
//  Before loading, it clears the chain. It drives the chain's serial input, shift enable and chain reset.
//  When exactly CHAIN_LENGTH bits have been shifted in, it signals completion.
// PARAMETERS
//  WORD_WIDTH    8    width of incoming bitstream words
//  CHAIN_LENGTH  146  total config bits in the chain (one tile = 146)
//  CLEAR_CYCLES  2    cycles config_nreset is held low before loading (>=1)
// PORTS
//  clock          in   1           system clock; also clocks the config chain
//  nreset         in   1           synchronous active-low reset
//  start          in   1           pulse: begin clear+load sequence (ignored unless IDLE)
//  abort          in   1           pulse: cancel load, return to IDLE
//  word_data      in   WORD_WIDTH  bitstream word, MSB = earliest bit
//  word_valid     in   1           word_data valid
//  word_ready     out  1           loader accepts word this cycle
//  config_out     out  1           serial bit into chain config_in
//  config_enable  out  1           chain shift enable
//  config_nreset  out  1           chain reset, active low
//  busy           out  1           high in any state but IDLE
//  done           out  1           one-cycle pulse: full chain loaded
// BEHAVIOUR
//  - Reset (nreset=0 at a clock edge):
//    - state=IDLE; word_ready=0, config_out=0, config_enable=0, config_nreset=1, busy=0, done=0.
//    - The bit counter and the shift register clear.
//  - All outputs are registered.
//  - FSM IDLE -> CLEAR -> LOAD <-> SHIFT -> DONE -> IDLE.
//  - IDLE:
//    - start=1 -> CLEAR; the clear counter is set to CLEAR_CYCLES.
//    - word_valid is ignored and word_ready=0.
//  - CLEAR:
//    - config_nreset=0 for exactly CLEAR_CYCLES cycles; config_enable=0.
//    - Then -> LOAD, and bits_left = CHAIN_LENGTH.
//  - LOAD:
//    - word_ready=1, config_enable=0.
//    - On word_valid&&word_ready, capture word_data into the shift register, then -> SHIFT.
//    - n = min(WORD_WIDTH, bits_left) bits of that word are used.
//  - SHIFT:
//    - config_enable=1 for exactly n consecutive cycles; config_out = current shift-register MSB.
//    - The shift register shifts left each cycle; bits_left decrements each cycle.
//    - First bit appears on config_out/enable the cycle after the handshake.
//    - After n bits: bits_left>0 -> LOAD, bits_left==0 -> DONE.
//    - word_ready=0 throughout SHIFT, so there is no back-to-back acceptance.
//    - Per-word throughput is n+1 cycles.
//  - Partial final word:
//    - When CHAIN_LENGTH % WORD_WIDTH != 0, only the top (CHAIN_LENGTH % WORD_WIDTH) bits of the last word are shifted.
//    - Its remaining low bits are discarded.
//    - Default: 19 words, the last word contributing 2 bits.
//  - Bit order: the first bit shifted ends in the chain's far end (config_data[CHAIN_LENGTH-1]).
//  - DONE: done=1 for one cycle, config_enable=0, then -> IDLE.
//  - start while busy: ignored.
//  - abort in any non-IDLE state:
//    - Next cycle state=IDLE; config_enable=0, word_ready=0, config_nreset=1.
//    - Partial chain contents are left as-is and done is not asserted.
//    - abort wins over simultaneous start/handshake.
//  - nreset mid-sequence: same as abort, with all counters cleared; no done.
//  - config_enable is never high while config_nreset=0.
//  - Counter width: $clog2(CHAIN_LENGTH+1).
// TESTING
//  - Reset, then 10 idle cycles -> outputs at reset values.
//  - word_valid=1 in IDLE -> word_ready stays 0.
//  - start pulse -> config_nreset low for exactly 2 cycles, then word_ready=1 on the next cycle.
//  - Full load of 19 words 0xA5,0x3C,...,0xC0, valid held high:
//    - exactly 146 config_enable cycles.
//    - config_out sequence equals the word MSB-first stream truncated to 146 bits.
//    - one done pulse; a chain model's config_data matches the stream.
//  - Throttle: word_valid toggled randomly -> enable count remains 146, no gaps inside a word, data identical.
//  - abort after word 7 -> IDLE next cycle, no further enables, no done.
//    - A new start then loads cleanly.
//  - nreset asserted during SHIFT -> all outputs at reset values after that edge.
//    - A subsequent full load passes.
//  - start pulsed during LOAD -> no restart; total enables still 146.

Source files
------------

// File: rtl/config_loader_if.sv
// Word stream interface feeding the configuration loader.
//   word_data  : bitstream word. The MSB is the earliest bit on the chain.
//   word_valid : the producer is presenting word_data.
//   word_ready : the loader will accept word_data at the next clock edge.
// A word transfers on a rising edge where word_valid && word_ready are both high.
// After the producer raises word_valid, it holds word_data stable until that transfer.
interface config_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/config_loader.sv
// config_loader: serializes bitstream words onto a tile's configuration shift chain.
// First it clears the chain. Then it shifts in exactly CHAIN_LENGTH bits, MSB-first,
// and pulses done.
// Ports:
//   clock, nreset      : system clock; synchronous active-low reset
//   start_i, abort_i   : start a clear+load sequence / cancel it
//   word_if (slave)    : word stream (see config_loader_if)
//   config_out_o       : serial bit into the chain
//   config_enable_o    : chain shift enable
//   config_nreset_o    : chain reset, active low
//   busy_o, done_o     : not-idle flag / one-cycle completion pulse
//   state_o            : current FSM state, for debug
// Every output is a register. Each output register is loaded from the next state.
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 146,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start_i,
  input  logic             abort_i,
  config_loader_if.slave   word_if,
  output logic             config_out_o,
  output logic             config_enable_o,
  output logic             config_nreset_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [2:0]       state_o
);
  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int KW = $clog2(CLEAR_CYCLES + 1);
  localparam int SW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]         bits_left_q, bits_left_d;
  // Bits still to be shifted from the current word after the one on config_out.
  logic [SW-1:0]         word_left_q, word_left_d;
  logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
  logic                  word_ready_q, word_ready_d;
  logic                  config_out_q, config_out_d;
  logic                  config_enable_q, config_enable_d;
  logic                  config_nreset_q, config_nreset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q         <= S_IDLE;
      clr_cnt_q       <= '0;
      bits_left_q     <= '0;
      word_left_q     <= '0;
      sreg_q          <= '0;
      word_ready_q    <= 1'b0;
      config_out_q    <= 1'b0;
      config_enable_q <= 1'b0;
      config_nreset_q <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      bits_left_q     <= bits_left_d;
      word_left_q     <= word_left_d;
      sreg_q          <= sreg_d;
      word_ready_q    <= word_ready_d;
      config_out_q    <= config_out_d;
      config_enable_q <= config_enable_d;
      config_nreset_q <= config_nreset_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    bits_left_d  = bits_left_q;
    word_left_d  = word_left_q;
    sreg_d       = sreg_q;
    config_out_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CLEAR;
          clr_cnt_d = KW'(CLEAR_CYCLES);
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == KW'(1)) begin
          state_d     = S_LOAD;
          clr_cnt_d   = '0;
          bits_left_d = CW'(CHAIN_LENGTH);
        end else begin
          clr_cnt_d = clr_cnt_q - KW'(1);
        end
      end
      S_LOAD: begin
        if (word_if.word_valid && word_ready_q) begin
          // The MSB goes straight to config_out. The rest waits in sreg.
          // A short last word keeps only the bits still owed to the chain.
          state_d      = S_SHIFT;
          config_out_d = word_if.word_data[WORD_WIDTH-1];
          sreg_d       = word_if.word_data << 1;
          bits_left_d  = bits_left_q - CW'(1);
          if (32'(bits_left_q) >= WORD_WIDTH) word_left_d = SW'(WORD_WIDTH - 1);
          else                                word_left_d = SW'(bits_left_q - CW'(1));
        end
      end
      S_SHIFT: begin
        if (word_left_q == '0) begin
          state_d = (bits_left_q == '0) ? S_DONE : S_LOAD;
        end else begin
          config_out_d = sreg_q[WORD_WIDTH-1];
          sreg_d       = sreg_q << 1;
          word_left_d  = word_left_q - SW'(1);
          bits_left_d  = bits_left_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort takes priority over any start or handshake. From IDLE it also blocks start.
    if (abort_i) state_d = S_IDLE;

    word_ready_d    = (state_d == S_LOAD);
    config_enable_d = (state_d == S_SHIFT);
    config_nreset_d = (state_d != S_CLEAR);
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    if (state_d != S_SHIFT) config_out_d = 1'b0;
  end

  assign word_if.word_ready = word_ready_q;
  assign config_out_o       = config_out_q;
  assign config_enable_o    = config_enable_q;
  assign config_nreset_o    = config_nreset_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign state_o            = state_q;
endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;
  localparam int WW = 8;
  localparam int CL = 146;
  localparam int NW = 19;

  logic clock, nreset, start_i, abort_i;
  logic config_out_o, config_enable_o, config_nreset_o, busy_o, done_o;
  logic [2:0] state_o;

  config_loader_if #(.WORD_WIDTH(WW)) wif ();

  config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CLEAR_CYCLES(2)) dut (
    .clock           (clock),
    .nreset          (nreset),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .word_if         (wif),
    .config_out_o    (config_out_o),
    .config_enable_o (config_enable_o),
    .config_nreset_o (config_nreset_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .state_o         (state_o)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- chain model / monitor ----------------
  logic [CL-1:0] chain;
  int en_cnt = 0, done_cnt = 0, bad_cnt = 0, run_len = 0;
  logic got_q[$];
  int   run_q[$];

  always @(posedge clock) begin
    if (!config_nreset_o)     chain <= '0;
    else if (config_enable_o) chain <= {chain[CL-2:0], config_out_o};
    if (config_enable_o) begin
      en_cnt++;
      got_q.push_back(config_out_o);
      run_len++;
      if (!config_nreset_o) bad_cnt++;
    end else if (run_len > 0) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
    if (done_o) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  int chk_cnt = 0, pass_cnt = 0;
  logic [WW-1:0] words [NW];
  logic [0:0]    exp_q[$];
  logic [CL-1:0] exp_chain;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, int'(wif.word_ready), 0);
    check({tag, "_out"},   int'(config_out_o), 0);
    check({tag, "_en"},    int'(config_enable_o), 0);
    check({tag, "_nres"},  int'(config_nreset_o), 1);
    check({tag, "_busy"},  int'(busy_o), 0);
    check({tag, "_done"},  int'(done_o), 0);
    check({tag, "_state"}, int'(state_o), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] d, input bit throttle);
    int n;
    if (throttle) begin
      wif.word_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wif.word_data  = d;
    wif.word_valid = 1'b1;
    n = 0;
    while (!wif.word_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("handshake_within_budget", int'(n < 200), 1);
    @(negedge clock);  // transfer happens on the posedge just passed
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!wif.word_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ready_seen"}, int'(wif.word_ready), 1);
  endtask

  task automatic do_load(input string tag, input bit throttle, input bit poke_start);
    int e0, d0, g0, r0, n, mism, runbad;
    e0 = en_cnt; d0 = done_cnt; g0 = got_q.size(); r0 = run_q.size();
    pulse_start();
    for (int i = 0; i < NW; i++) begin
      if (poke_start && i == 5) begin
        wif.word_valid = 1'b0;
        wait_ready({tag, "_poke"});
        pulse_start();
      end
      send_word(words[i], throttle);
    end
    wif.word_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    check({tag, "_enable_count"}, en_cnt - e0, CL);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    mism = 0;
    for (int k = 0; k < CL; k++)
      if (g0 + k >= got_q.size() || got_q[g0 + k] !== exp_q[k][0]) mism++;
    check({tag, "_stream_mismatches"}, mism, 0);
    mism = 0;
    for (int k = 0; k < CL; k++)
      if (chain[k] !== exp_chain[k]) mism++;
    check({tag, "_chain_mismatches"}, mism, 0);
    runbad = 0;
    for (int k = 0; k < NW; k++) begin
      if (r0 + k >= run_q.size()) runbad++;
      else if (run_q[r0 + k] != ((k == NW - 1) ? (CL % WW) : WW)) runbad++;
    end
    check({tag, "_bad_runs"}, runbad, 0);
    check({tag, "_busy_after"}, int'(busy_o), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic       abort;
    logic       valid;
    logic       exp_ready;
    logic       exp_nres;
    logic       exp_en;
    logic       exp_busy;
    logic       exp_done;
    logic [2:0] exp_state;
  } vec_t;
  vec_t vec [7];

  initial begin
    // Stimulus words, MSB first; the last word contributes only its top 2 bits.
    words = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'h12, 8'h34,
              8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'hE7, 8'h81, 8'hC0};
    for (int w = 0; w < NW; w++)
      for (int b = WW - 1; b >= 0; b--)
        if (exp_q.size() < CL) exp_q.push_back(words[w][b]);
    // The first bit shifted ends at the far end of the chain.
    for (int k = 0; k < CL; k++) exp_chain[CL - 1 - k] = exp_q[k][0];

    //          start abort valid rdy  nres en   busy done state
    vec[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}; // valid ignored in IDLE
    vec[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1}; // clear cycle 1
    vec[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1}; // clear cycle 2
    vec[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2}; // LOAD, ready
    vec[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2}; // start ignored
    vec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}; // abort from LOAD
    vec[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}; // back in IDLE

    // ---------------- reset ----------------
    nreset = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    wif.word_valid = 1'b0; wif.word_data = '0;
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    check_idle_outputs("reset");
    repeat (10) @(negedge clock);
    check_idle_outputs("idle10");

    // ---------------- table-driven control vectors ----------------
    for (int i = 0; i < 7; i++) begin
      start_i = vec[i].start; abort_i = vec[i].abort; wif.word_valid = vec[i].valid;
      @(negedge clock);
      check($sformatf("vec%0d_ready", i), int'(wif.word_ready), int'(vec[i].exp_ready));
      check($sformatf("vec%0d_nres", i),  int'(config_nreset_o), int'(vec[i].exp_nres));
      check($sformatf("vec%0d_en", i),    int'(config_enable_o), int'(vec[i].exp_en));
      check($sformatf("vec%0d_busy", i),  int'(busy_o), int'(vec[i].exp_busy));
      check($sformatf("vec%0d_done", i),  int'(done_o), int'(vec[i].exp_done));
      check($sformatf("vec%0d_state", i), int'(state_o), int'(vec[i].exp_state));
    end
    start_i = 1'b0; abort_i = 1'b0; wif.word_valid = 1'b0;
    @(negedge clock);

    // ---------------- full load, valid held high ----------------
    do_load("full", 1'b0, 1'b0);

    // ---------------- throttled valid ----------------
    do_load("throttle", 1'b1, 1'b0);

    // ---------------- abort after word 7 ----------------
    begin
      int e0, d0;
      e0 = en_cnt; d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 7; i++) send_word(words[i], 1'b0);
      wif.word_valid = 1'b0;
      wait_ready("abort");
      abort_i = 1'b1;
      @(negedge clock);
      abort_i = 1'b0;
      check("abort_busy",  int'(busy_o), 0);
      check("abort_ready", int'(wif.word_ready), 0);
      check("abort_en",    int'(config_enable_o), 0);
      check("abort_nres",  int'(config_nreset_o), 1);
      check("abort_state", int'(state_o), 0);
      repeat (20) @(negedge clock);
      check("abort_enable_count", en_cnt - e0, 7 * WW);
      check("abort_no_done", done_cnt - d0, 0);
    end
    do_load("after_abort", 1'b0, 1'b0);

    // ---------------- nreset during SHIFT ----------------
    begin
      int d0;
      d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 4; i++) send_word(words[i], 1'b0);
      wif.word_valid = 1'b0;
      check("rst_mid_shifting", int'(config_enable_o), 1);
      nreset = 1'b0;
      @(negedge clock);
      check_idle_outputs("rst_mid");
      nreset = 1'b1;
      repeat (5) @(negedge clock);
      check("rst_mid_no_done", done_cnt - d0, 0);
    end
    do_load("after_reset", 1'b0, 1'b0);

    // ---------------- start pulsed during LOAD ----------------
    do_load("start_in_load", 1'b0, 1'b1);

    check("enable_while_chain_reset", bad_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
